// File: rtl/trigger_pkg.sv
// Shared types and constants for the trigger capture block: FSM states, edge selection
// encoding and the holdoff window length used when TRIGGER_CAPTURE_HOLDOFF_EN is defined.
package trigger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2
    } cap_state_t;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2,
        EDGE_NONE = 2'd3
    } edge_sel_t;

    localparam int HOLDOFF_CYCLES = 8;

    function automatic logic edge_match(input edge_sel_t sel, input logic rise, input logic fall);
        logic hit;
        hit = 1'b0;
        case (sel)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/trig_fifo.sv
// First-word-fall-through synchronous FIFO; head visible the cycle after the first push.
// A push while full is refused unless a pop happens in the same cycle; pop while empty is ignored.
module trig_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset, so the head is masked to zero whenever nothing valid is held.
    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/trigger_capture.sv
// Synchronises trig_in, timestamps qualifying edges (pin to FIFO write <= SYNC_STAGES+1 cycles);
// full FIFO drops events into the sticky overflow flag. TRIGGER_CAPTURE_HOLDOFF_EN adds a post-capture holdoff.
module trigger_capture
    import trigger_pkg::*;
#(
    parameter int TS_WIDTH    = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      trig_in,
    input  logic                      arm,
    input  logic [1:0]                edge_sel,
    input  logic                      rd_en,
    input  logic                      clr_ovf,
    output logic [TS_WIDTH-1:0]       ts_out,
    output logic                      ts_valid,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow,
    output logic                      armed
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q;
    logic [TS_WIDTH-1:0]    cnt_q, cnt_d;
    cap_state_t             state_q, state_d;
    logic                   ovf_q, ovf_d;
    logic                   sync_s, rise, fall, evt, capture, drop;
    logic                   fifo_full, fifo_empty;
    edge_sel_t              sel;

`ifdef TRIGGER_CAPTURE_HOLDOFF_EN
    localparam int HO_W = $clog2(HOLDOFF_CYCLES);
    logic [HO_W-1:0] ho_cnt_q, ho_cnt_d;
`endif

    assign sync_d = {sync_q[SYNC_STAGES-2:0], trig_in};
    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = sync_s & ~s_d_q;
    assign fall   = ~sync_s & s_d_q;
    assign sel    = edge_sel_t'(edge_sel);
    assign evt    = edge_match(sel, rise, fall);
    assign cnt_d  = cnt_q + TS_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
`ifdef TRIGGER_CAPTURE_HOLDOFF_EN
        ho_cnt_d = ho_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arm) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                // An event in the cycle arm drops is still captured.
                capture = evt;
                if (!arm) begin
                    state_d = ST_IDLE;
                end
`ifdef TRIGGER_CAPTURE_HOLDOFF_EN
                else if (evt) begin
                    state_d  = ST_HOLDOFF;
                    ho_cnt_d = HO_W'(HOLDOFF_CYCLES - 1);
                end
`endif
            end
            ST_HOLDOFF: begin
`ifdef TRIGGER_CAPTURE_HOLDOFF_EN
                if (!arm)                state_d = ST_IDLE;
                else if (ho_cnt_q == '0) state_d = ST_ARMED;
                else                     ho_cnt_d = ho_cnt_q - HO_W'(1);
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Only a full FIFO drops; holdoff-suppressed events never reach capture.
    assign drop  = capture & fifo_full & ~(rd_en & ~fifo_empty);
    assign ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            s_d_q    <= 1'b0;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            ovf_q    <= 1'b0;
`ifdef TRIGGER_CAPTURE_HOLDOFF_EN
            ho_cnt_q <= '0;
`endif
        end else begin
            sync_q   <= sync_d;
            s_d_q    <= sync_s;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            ovf_q    <= ovf_d;
`ifdef TRIGGER_CAPTURE_HOLDOFF_EN
            ho_cnt_q <= ho_cnt_d;
`endif
        end
    end

    trig_fifo #(
        .WIDTH (TS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (capture),
        .push_dat_i (cnt_q),
        .pop_i      (rd_en),
        .head_dat_o (ts_out),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign ts_valid = ~fifo_empty;
    assign overflow = ovf_q;
    assign armed    = (state_q != ST_IDLE);

endmodule
